// File: rtl/firmware_config_sequencer_if.sv
// Host byte stream, session control and shared configId/configData bus of the firmware sequencer.
// slave is the sequencer side; master is the host / bench side.
interface firmware_config_sequencer_if;
  logic       cfg_start;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       hold_inputs;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;

  modport slave (
    input  cfg_start, host_valid, host_data,
    output host_ready, hold_inputs, tracing, configId, configData, busy, done
  );

  modport master (
    output cfg_start, host_valid, host_data,
    input  host_ready, hold_inputs, tracing, configId, configData, busy, done
  );
endinterface

// File: rtl/firmware_config_sequencer.sv
// Buffers each block's firmware image from the host byte stream, then bursts it back-to-back
// onto configId/configData while tracing is dropped and the datapath input is held off.
module firmware_config_sequencer #(
  parameter int         NUM_BLOCKS      = 4,
  parameter int         MAX_CHAINS      = 4,
  parameter int         BYTES_PER_BLOCK = MAX_CHAINS * 5,
  parameter logic [7:0] FIRST_CONFIG_ID = 8'd1,
  parameter logic [7:0] IDLE_CONFIG_ID  = 8'hFF,
  parameter int         DRAIN_CYCLES    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  firmware_config_sequencer_if.slave  cfg_if
);

  localparam int BYTE_W  = $clog2(BYTES_PER_BLOCK + 1);
  localparam int BLK_W   = $clog2(NUM_BLOCKS + 1);
  localparam int ADDR_W  = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BYTES_PER_BLOCK - 1);
  localparam logic [BLK_W-1:0]   LAST_BLK   = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FILL,
    S_BURST,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                tracing_q, tracing_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          cfg_id_q, cfg_id_d;
  logic [7:0]          cfg_data_q;

  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          img_mem [BYTES_PER_BLOCK];

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    cfg_id_d    = IDLE_CONFIG_ID;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_if.cfg_start) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_FILL;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end
      S_FILL: begin
        if (cfg_if.host_valid) begin
          wr_en = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            // Prefetch byte 0 so the first BURST cycle already carries data.
            byte_cnt_d = '0;
            state_d    = S_BURST;
            cfg_id_d   = FIRST_CONFIG_ID + 8'(blk_cnt_q);
            rd_en      = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_BURST: begin
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = '0;
          state_d    = S_GAP;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          cfg_id_d   = FIRST_CONFIG_ID + 8'(blk_cnt_q);
          rd_en      = 1'b1;
          rd_addr    = ADDR_W'(byte_cnt_q + 1'b1);
        end
      end
      S_GAP: begin
        if (blk_cnt_q == LAST_BLK) begin
          blk_cnt_d = '0;
          state_d   = S_IDLE;
          done_d    = 1'b1;
        end else begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          state_d   = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered, so they line up with state_q.
    tracing_d = (state_d == S_IDLE) || (state_d == S_DRAIN);
    hold_d    = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      byte_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      tracing_q   <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_id_q    <= IDLE_CONFIG_ID;
      cfg_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      tracing_q   <= tracing_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_id_q    <= cfg_id_d;
      cfg_data_q  <= rd_en ? img_mem[rd_addr] : 8'h00;
    end
  end

  // Image buffer has no reset; its contents are meaningless until refilled.
  always_ff @(posedge clk) begin
    if (wr_en) img_mem[byte_cnt_q[ADDR_W-1:0]] <= cfg_if.host_data;
  end

  assign cfg_if.host_ready  = (state_q == S_FILL);
  assign cfg_if.hold_inputs = hold_q;
  assign cfg_if.tracing     = tracing_q;
  assign cfg_if.configId    = cfg_id_q;
  assign cfg_if.configData  = cfg_data_q;
  assign cfg_if.busy        = busy_q;
  assign cfg_if.done        = done_q;

endmodule

// File: tb/tb_firmware_config_sequencer.sv
// Randomized bench for firmware_config_sequencer: sessions are recorded cycle by cycle and
// compared against the expected burst stream, control timing and session length.
`timescale 1ns/1ps
module tb_firmware_config_sequencer;
  localparam int         NB       = 2;
  localparam int         MC       = 4;
  localparam int         BPB      = MC * 5;
  localparam int         DRAIN    = 4;
  localparam int         TOTAL    = NB * BPB;
  localparam logic [7:0] FIRST_ID = 8'd1;
  localparam logic [7:0] IDLE_ID  = 8'hFF;
  localparam int         TAIL     = 8;
  localparam int         MAX_CYC  = 3000;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
    logic       trc;
    logic       hold;
    logic       rdy;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int stream;
    int runs;
    int gap;
    int zero;
    int rdy;
    int ctrl;
    int dones;
  } score_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] host_bytes [TOTAL];
  obs_t       log_q [$];
  bit         fill_valid_q [$];

  always #5 clk = ~clk;

  firmware_config_sequencer_if bus_if ();

  firmware_config_sequencer #(
    .NUM_BLOCKS      (NB),
    .MAX_CHAINS      (MC),
    .BYTES_PER_BLOCK (BPB),
    .FIRST_CONFIG_ID (FIRST_ID),
    .IDLE_CONFIG_ID  (IDLE_ID),
    .DRAIN_CYCLES    (DRAIN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_if (bus_if)
  );

  // Drives one session from a cfg_start pulse and records every cycle (log_q[c-1] is cycle c,
  // cycle 1 being the one after the edge that sampled cfg_start).
  task automatic run_session(input int stall_mode, input bit repulse, input int abort_blk,
                             input int abort_pos, output int done_cyc, output bit timed_out,
                             output bit aborted);
    int         idx, fill_j, cyc, tail, burst_pos;
    logic [7:0] prev_id;
    bit         v;
    obs_t       o;
    idx = 0; fill_j = 0; cyc = 0; tail = -1; burst_pos = 0; prev_id = IDLE_ID;
    done_cyc = -1; timed_out = 1'b0; aborted = 1'b0;
    log_q.delete();
    fill_valid_q.delete();
    @(negedge clk);
    bus_if.cfg_start  = 1'b1;
    bus_if.host_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_if.cfg_start = 1'b0;
      o.id   = bus_if.configId;
      o.data = bus_if.configData;
      o.trc  = bus_if.tracing;
      o.hold = bus_if.hold_inputs;
      o.rdy  = bus_if.host_ready;
      o.busy = bus_if.busy;
      o.done = bus_if.done;
      log_q.push_back(o);
      if (o.id != IDLE_ID) burst_pos = (o.id == prev_id) ? burst_pos + 1 : 0;
      if (abort_blk >= 0 && o.id == FIRST_ID + 8'(abort_blk) && burst_pos == abort_pos) begin
        aborted = 1'b1;
        bus_if.host_valid = 1'b0;
        return;
      end
      // Re-pulse on the first cycle of each burst and on each gap cycle.
      if (repulse && o.busy && ((o.id != IDLE_ID) != (prev_id != IDLE_ID))) bus_if.cfg_start = 1'b1;
      if (bus_if.host_ready) begin
        case (stall_mode)
          0:       v = 1'b1;
          1:       v = (fill_j % 3 == 0);
          default: v = ($urandom_range(0, 1) == 1);
        endcase
        fill_j++;
        if (idx >= TOTAL) v = 1'b0;
        fill_valid_q.push_back(v);
        bus_if.host_valid = v;
        bus_if.host_data  = v ? host_bytes[idx] : 8'($urandom);
        if (v) idx++;
      end else begin
        // Junk outside FILL must never be consumed.
        bus_if.host_valid = ($urandom_range(0, 1) == 1);
        bus_if.host_data  = 8'($urandom);
      end
      if (o.done && done_cyc < 0) begin
        done_cyc = cyc;
        tail = TAIL;
      end
      if (tail == 0) begin
        bus_if.host_valid = 1'b0;
        return;
      end
      if (tail > 0) tail--;
      if (cyc >= MAX_CYC) begin
        timed_out = 1'b1;
        bus_if.host_valid = 1'b0;
        return;
      end
      prev_id = o.id;
    end
  endtask

  // Edges from the cfg_start edge to the done edge: drain, fill cycles, then burst+gap per block.
  function automatic int model_edges(input int stall_mode);
    int fill, got;
    fill = 0; got = 0;
    if (stall_mode == 0) fill = TOTAL;
    else if (stall_mode == 1) begin
      for (int j = 0; got < TOTAL; j++) begin
        if (j % 3 == 0) got++;
        fill++;
      end
    end else begin
      foreach (fill_valid_q[j]) if (got < TOTAL) begin
        fill++;
        if (fill_valid_q[j]) got++;
      end
    end
    return DRAIN + fill + NB * (BPB + 1);
  endfunction

  // Counts deviations of the recorded session from the expected stream and control timing.
  task automatic score_session(input int exp_edges, output score_t s);
    int   exp_done, pos, run_len, nruns;
    bit   in_sess, exp_trc;
    obs_t o;
    s = '{default: 0};
    exp_done = exp_edges + 1;
    pos = 0; run_len = 0; nruns = 0;
    for (int c = 1; c <= log_q.size(); c++) begin
      o = log_q[c-1];
      in_sess = (c < exp_done);
      exp_trc = !(c > DRAIN && c < exp_done);
      if (o.trc !== exp_trc || o.hold !== in_sess || o.busy !== in_sess || o.done !== (c == exp_done))
        s.ctrl++;
      if (o.done === 1'b1) s.dones++;
      if (o.rdy === 1'b1 && !(o.id == IDLE_ID && o.trc === 1'b0 && o.hold === 1'b1)) s.rdy++;
      if (o.id == IDLE_ID) begin
        if (o.data !== 8'h00) s.zero++;
        if (run_len != 0) begin
          if (run_len != BPB) s.runs++;
          if (c >= log_q.size()) s.gap++;
          else if (nruns < NB && log_q[c].rdy !== 1'b1) s.gap++;
          else if (nruns >= NB && log_q[c].done !== 1'b1) s.gap++;
          run_len = 0;
        end
      end else begin
        if (run_len == 0) nruns++;
        if (pos >= TOTAL) s.stream++;
        else if (o.id !== FIRST_ID + 8'(pos / BPB) || o.data !== host_bytes[pos]) s.stream++;
        pos++;
        run_len++;
      end
    end
    if (pos != TOTAL) s.stream++;
    if (nruns != NB) s.runs++;
  endtask

  task automatic test_reset();
    bus_if.cfg_start = 1'b0; bus_if.host_valid = 1'b0; bus_if.host_data = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (bus_if.configId !== IDLE_ID || bus_if.configData !== 8'h00) begin
      errors++; $display("FAIL reset_bus: got id=%0h data=%0h expected id=ff data=0", bus_if.configId, bus_if.configData);
    end
    checks++;
    if ({bus_if.tracing, bus_if.hold_inputs, bus_if.host_ready, bus_if.busy, bus_if.done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got trc,hold,rdy,busy,done=%b expected 00000",
        {bus_if.tracing, bus_if.hold_inputs, bus_if.host_ready, bus_if.busy, bus_if.done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.tracing !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.hold_inputs !== 1'b0 || bus_if.configId !== IDLE_ID) begin
      errors++; $display("FAIL reset_release: got trc=%b busy=%b hold=%b id=%0h expected 1 0 0 ff",
        bus_if.tracing, bus_if.busy, bus_if.hold_inputs, bus_if.configId);
    end
    $display("reset: released, tracing=%b", bus_if.tracing);
  endtask

  task automatic test_full_load();
    int done_cyc; bit to, ab; score_t s;
    for (int i = 0; i < TOTAL; i++) host_bytes[i] = 8'(i);
    run_session(0, 1'b0, -1, 0, done_cyc, to, ab);
    checks++;
    if (to) begin errors++; $display("FAIL full_load_timeout: got no done within %0d cycles expected done", MAX_CYC); end
    checks++;
    if (done_cyc - 1 != DRAIN + NB * (2 * BPB + 1)) begin
      errors++; $display("FAIL full_load_length: got %0d edges expected %0d", done_cyc - 1, DRAIN + NB * (2 * BPB + 1));
    end
    score_session(DRAIN + NB * (2 * BPB + 1), s);
    checks++;
    if (s.stream != 0 || s.runs != 0 || s.gap != 0) begin
      errors++; $display("FAIL full_load_stream: got stream=%0d run=%0d gap=%0d errors expected 0", s.stream, s.runs, s.gap);
    end
    checks++;
    if (s.ctrl != 0 || s.zero != 0 || s.rdy != 0 || s.dones != 1) begin
      errors++; $display("FAIL full_load_ctrl: got ctrl=%0d zero=%0d rdy=%0d dones=%0d expected 0 0 0 1", s.ctrl, s.zero, s.rdy, s.dones);
    end
    $display("full_load: done after %0d edges", done_cyc - 1);
  endtask

  task automatic test_drain();
    int done_cyc; bit to, ab; int bad;
    foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
    run_session(0, 1'b0, -1, 0, done_cyc, to, ab);
    checks++;
    if (log_q.size() <= DRAIN || log_q[0].hold !== 1'b1) begin
      errors++; $display("FAIL drain_hold: got hold=%b on cycle 1 expected 1", (log_q.size() > 0) ? log_q[0].hold : 1'bx);
    end
    bad = 0;
    for (int c = 1; c <= DRAIN && c <= log_q.size(); c++)
      if (log_q[c-1].trc !== 1'b1 || log_q[c-1].rdy !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drain_trace: got %0d cycles with trc!=1 or rdy!=0 expected 0", bad); end
    checks++;
    if (log_q.size() <= DRAIN || log_q[DRAIN].trc !== 1'b0 || log_q[DRAIN].rdy !== 1'b1) begin
      errors++; $display("FAIL drain_fill_entry: got trc=%b rdy=%b on cycle %0d expected 0 1",
        (log_q.size() > DRAIN) ? log_q[DRAIN].trc : 1'bx, (log_q.size() > DRAIN) ? log_q[DRAIN].rdy : 1'bx, DRAIN + 1);
    end
    $display("drain: fill entered on cycle %0d", DRAIN + 1);
  endtask

  task automatic test_host_stalls();
    int done_cyc; bit to, ab; score_t s; int exp;
    for (int mode = 1; mode <= 2; mode++) begin
      foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
      run_session(mode, 1'b0, -1, 0, done_cyc, to, ab);
      exp = model_edges(mode);
      checks++;
      if (to || done_cyc - 1 != exp) begin
        errors++; $display("FAIL stall_length_mode%0d: got %0d edges (timeout=%0d) expected %0d", mode, done_cyc - 1, to, exp);
      end
      score_session(exp, s);
      checks++;
      if (s.stream != 0 || s.runs != 0 || s.gap != 0) begin
        errors++; $display("FAIL stall_stream_mode%0d: got stream=%0d run=%0d gap=%0d errors expected 0", mode, s.stream, s.runs, s.gap);
      end
      checks++;
      if (s.rdy != 0 || s.ctrl != 0 || s.zero != 0) begin
        errors++; $display("FAIL stall_ctrl_mode%0d: got rdy=%0d ctrl=%0d zero=%0d errors expected 0", mode, s.rdy, s.ctrl, s.zero);
      end
      $display("host_stalls mode %0d: done after %0d edges", mode, done_cyc - 1);
    end
  endtask

  task automatic test_cfg_start_ignored();
    int done_cyc; bit to, ab; score_t s;
    foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
    run_session(2, 1'b1, -1, 0, done_cyc, to, ab);
    score_session(model_edges(2), s);
    checks++;
    if (to || s.dones != 1) begin
      errors++; $display("FAIL repulse_done: got %0d done pulses (timeout=%0d) expected 1", s.dones, to);
    end
    checks++;
    if (s.stream != 0 || s.runs != 0 || s.ctrl != 0) begin
      errors++; $display("FAIL repulse_stream: got stream=%0d run=%0d ctrl=%0d errors expected 0", s.stream, s.runs, s.ctrl);
    end
    $display("cfg_start_ignored: done after %0d edges", done_cyc - 1);
  endtask

  task automatic test_reset_mid_burst();
    int done_cyc; bit to, ab; score_t s;
    foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
    run_session(0, 1'b0, 1, 7, done_cyc, to, ab);
    checks++;
    if (!ab) begin errors++; $display("FAIL midburst_reach: got no block-1 burst expected one"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.configId !== IDLE_ID || bus_if.configData !== 8'h00 ||
        {bus_if.tracing, bus_if.hold_inputs, bus_if.host_ready, bus_if.busy, bus_if.done} !== 5'b0) begin
      errors++; $display("FAIL midburst_async_reset: got id=%0h data=%0h ctrl=%b expected ff 0 00000", bus_if.configId,
        bus_if.configData, {bus_if.tracing, bus_if.hold_inputs, bus_if.host_ready, bus_if.busy, bus_if.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
    run_session(0, 1'b0, -1, 0, done_cyc, to, ab);
    score_session(DRAIN + NB * (2 * BPB + 1), s);
    checks++;
    if (to || s.stream != 0 || s.runs != 0 || s.ctrl != 0 || s.dones != 1) begin
      errors++; $display("FAIL midburst_rerun: got stream=%0d run=%0d ctrl=%0d dones=%0d timeout=%0d expected 0 0 0 1 0",
        s.stream, s.runs, s.ctrl, s.dones, to);
    end
    $display("reset_mid_burst: rerun done after %0d edges", done_cyc - 1);
  endtask

  // Replays the bus through simple block receivers whose byte counter clears when not addressed.
  task automatic test_end_to_end();
    int done_cyc; bit to, ab; int bad, ovf, leftover;
    logic [7:0] cap [NB][BPB];
    int cnt [NB];
    foreach (host_bytes[i]) host_bytes[i] = 8'($urandom);
    run_session(2, 1'b0, -1, 0, done_cyc, to, ab);
    ovf = 0;
    foreach (cnt[b]) cnt[b] = 0;
    foreach (cap[b, k]) cap[b][k] = 8'h00;
    foreach (log_q[c]) for (int b = 0; b < NB; b++) begin
      if (log_q[c].id == FIRST_ID + 8'(b)) begin
        if (cnt[b] < BPB) cap[b][cnt[b]] = log_q[c].data; else ovf++;
        cnt[b]++;
      end else cnt[b] = 0;
    end
    bad = 0;
    for (int k = 0; k < MC; k++) if (cap[1][k] !== host_bytes[BPB + k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL e2e_firmware_op: got %0d wrong op bytes, op0=%0h expected op0=%0h", bad, cap[1][0], host_bytes[BPB]);
    end
    bad = 0; leftover = 0;
    foreach (cap[b, k]) if (cap[b][k] !== host_bytes[b * BPB + k]) bad++;
    foreach (cnt[b]) leftover += cnt[b];
    checks++;
    if (to || bad != 0 || ovf != 0 || leftover != 0) begin
      errors++; $display("FAIL e2e_images: got bad=%0d overflow=%0d counter_left=%0d timeout=%0d expected all 0", bad, ovf, leftover, to);
    end
    $display("end_to_end: %0d blocks loaded, done after %0d edges", NB, done_cyc - 1);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_drain();
    test_host_stalls();
    test_cfg_start_ignored();
    test_reset_mid_burst();
    test_end_to_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
